// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle ADD/SUB/AND/OR/NOT and a
// one-bit-per-cycle iterative shifter that stalls upstream via in_ready.
module alu_exec_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         alu_op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         flag_cmd,
  input  logic [2:0]         dest_in,
  input  logic               wb_en_in,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [2:0]         out_dest,
  output logic               out_wb_en,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c,
  output logic               illegal
);

  localparam logic [6:0] OP_ADD = 7'b0000001;
  localparam logic [6:0] OP_SUB = 7'b0000010;
  localparam logic [6:0] OP_AND = 7'b0000100;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_NOT = 7'b0010000;
  localparam logic [6:0] OP_SHR = 7'b0100000;
  localparam logic [6:0] OP_SHL = 7'b1000000;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         dest_q, dest_d;
  logic               wb_q, wb_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shl_q, shl_d;
  logic [2:0]         pdest_q, pdest_d;
  logic               pwb_q, pwb_d;

  logic               onehot;
  logic               long_shift;
  logic               upd_zn;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   shifted;
  logic               shift_out;

  assign onehot     = (alu_op != 7'd0) && ((alu_op & (alu_op - 7'd1)) == 7'd0);
  assign long_shift = onehot && (alu_op[5] || alu_op[6]) && (shamt != '0);
  assign sum        = {1'b0, op_a} + {1'b0, op_b};
  // The extra MSB of the widened difference is the unsigned borrow.
  assign diff       = {1'b0, op_a} - {1'b0, op_b};
  assign shifted    = shl_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
  assign shift_out  = shl_q ? work_q[WIDTH-1] : work_q[0];

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    dest_d    = dest_q;
    wb_d      = wb_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    pdest_d   = pdest_q;
    pwb_d     = pwb_q;
    upd_zn    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (long_shift) begin
            work_d  = op_a;
            cnt_d   = shamt;
            shl_d   = alu_op[6];
            pdest_d = dest_in;
            pwb_d   = wb_en_in;
            state_d = SHIFT;
          end else begin
            dest_d   = dest_in;
            wb_d     = wb_en_in;
            valid_d  = 1'b1;
            result_d = op_a;
            if (!onehot) begin
              illegal_d = (alu_op != 7'd0);
              if (alu_op == 7'd0) begin
                if (flag_cmd == 2'b01) c_d = 1'b1;
                else if (flag_cmd == 2'b10) c_d = 1'b0;
              end
            end else begin
              upd_zn = 1'b1;
              case (alu_op)
                OP_ADD: begin result_d = sum[WIDTH-1:0];  c_d = sum[WIDTH];  end
                OP_SUB: begin result_d = diff[WIDTH-1:0]; c_d = diff[WIDTH]; end
                OP_AND: result_d = op_a & op_b;
                OP_OR:  result_d = op_a | op_b;
                OP_NOT: result_d = ~op_a;
                OP_SHR, OP_SHL: result_d = op_a;
                default: result_d = op_a;
              endcase
            end
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_d = shifted;
            c_d      = shift_out;
            upd_zn   = 1'b1;
            valid_d  = 1'b1;
            dest_d   = pdest_q;
            wb_d     = pwb_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (upd_zn) begin
      z_d = (result_d == '0);
      n_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      dest_q    <= '0;
      wb_q      <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      shl_q     <= 1'b0;
      pdest_q   <= '0;
      pwb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      dest_q    <= dest_d;
      wb_q      <= wb_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      shl_q     <= shl_d;
      pdest_q   <= pdest_d;
      pwb_q     <= pwb_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign result    = result_q;
  assign out_dest  = dest_q;
  assign out_wb_en = wb_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  alu_op = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [3:0]  shamt = '0;
  logic [1:0]  flag_cmd = '0;
  logic [2:0]  dest_in = '0;
  logic        wb_en_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] result;
  logic [2:0]  out_dest;
  logic        out_wb_en, flag_z, flag_n, flag_c, illegal;

  int n_pass = 0;
  int n_total = 0;

  alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .flag_cmd(flag_cmd), .dest_in(dest_in), .wb_en_in(wb_en_in), .flush(flush),
    .out_valid(out_valid), .result(result), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] sh, input logic [1:0] fc, input logic [2:0] d,
                     input logic wb);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b;
    shamt = sh; flag_cmd = fc; dest_in = d; wb_en_in = wb;
  endtask

  // Packs {out_valid, illegal, Z, N, C} for compact flag checks.
  function automatic logic [31:0] st();
    return {27'd0, out_valid, illegal, flag_z, flag_n, flag_c};
  endfunction

  initial begin
    int n;
    int hits;
    tick(); tick();
    chk("rst_result", result, 0);
    chk("rst_state", st(), 0);
    chk("rst_dest_wb", {out_dest, out_wb_en}, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // ADD 0x7FFF + 1
    drv(7'b0000001, 16'h7FFF, 16'h0001, 0, 0, 3'd3, 1'b1); tick();
    in_valid = 1'b0;
    chk("add_result", result, 16'h8000);
    chk("add_flags", st(), 5'b10010);
    chk("add_dest_wb", {out_dest, out_wb_en}, {3'd3, 1'b1});
    tick();
    chk("add_pulse_end", out_valid, 0);
    chk("add_hold", result, 16'h8000);

    // Back-to-back SUBs
    drv(7'b0000010, 16'h0005, 16'h0005, 0, 0, 3'd1, 1'b0); tick();
    chk("sub0_result", result, 16'h0000);
    chk("sub0_flags", st(), 5'b10100);
    drv(7'b0000010, 16'h0003, 16'h0005, 0, 0, 3'd2, 1'b1); tick();
    chk("sub1_result", result, 16'hFFFE);
    chk("sub1_flags", st(), 5'b10011);
    chk("sub1_ready", in_ready, 1);

    // SHL 0x9001 by 4
    drv(7'b1000000, 16'h9001, 16'h0000, 4'd4, 0, 3'd5, 1'b1); tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      chk("shl_ready_low", in_ready, 0);
      tick(); n++;
    end
    chk("shl_latency", n, 4);
    chk("shl_result", result, 16'h0010);
    chk("shl_flags", st(), 5'b10001);
    chk("shl_dest", out_dest, 3'd5);
    chk("shl_ready_back", in_ready, 1);

    // SHR 0x0003 by 1
    drv(7'b0100000, 16'h0003, 16'h0000, 4'd1, 0, 3'd6, 1'b1); tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("shr_latency", n, 1);
    chk("shr_result", result, 16'h0001);
    chk("shr_flags", st(), 5'b10001);

    // No-ALU op: flag_cmd clear then set carry
    drv(7'b0000000, 16'hABCD, 16'h0000, 0, 2'b10, 3'd0, 1'b0); tick();
    chk("nop_clr_result", result, 16'hABCD);
    chk("nop_clr_flags", st(), 5'b10000);
    drv(7'b0000000, 16'h0000, 16'h0000, 0, 2'b01, 3'd0, 1'b0); tick();
    chk("nop_set_flags", st(), 5'b10001);

    // Illegal op, flag_cmd must be ignored
    drv(7'b0000011, 16'h1234, 16'h0001, 0, 2'b10, 3'd4, 1'b1); tick();
    in_valid = 1'b0;
    chk("ill_result", result, 16'h1234);
    chk("ill_flags", st(), 5'b11001);
    tick();
    chk("ill_pulse_end", st(), 5'b00001);

    // SHL 0xFFFF by 8 aborted by flush at E3
    drv(7'b1000000, 16'hFFFF, 16'h0000, 4'd8, 0, 3'd7, 1'b1); tick();
    in_valid = 1'b0;
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_ready", in_ready, 1);
    chk("flush_flags", st(), 5'b00001);
    hits = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (out_valid) hits++; end
    chk("flush_no_valid", hits, 0);
    chk("flush_hold", result, 16'h1234);

    // in_valid ignored on a flush edge, accepted on the next one
    drv(7'b0000001, 16'h0001, 16'h0001, 0, 0, 3'd2, 1'b1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_ignore_in", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("add2_result", result, 16'h0002);
    chk("add2_flags", st(), 5'b10000);

    // ADD carry-out with zero result
    drv(7'b0000001, 16'hFFFF, 16'h0001, 0, 0, 3'd1, 1'b1); tick();
    in_valid = 1'b0;
    chk("addc_flags", st(), 5'b10101);

    // SHR by 15 interrupted by asynchronous reset
    drv(7'b0100000, 16'h8000, 16'h0000, 4'd15, 0, 3'd3, 1'b1); tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_state", st(), 0);
    chk("arst_dest_wb", {out_dest, out_wb_en}, 0);
    chk("arst_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (out_valid) hits++; end
    chk("arst_no_valid", hits, 0);
    chk("arst_ready_hold", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage datapath that consumes the 7-bit one-hot ALU operation code produced by the ALU control decoder, together with two 16-bit operands from the register-read stage. It performs the operation, registers the result and destination for write-back, and maintains the Z/N/C condition flags. ADD/SUB/AND/OR/NOT complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter and stall the upstream stage through a ready handshake.

## Interface
- WIDTH, 16, datapath width
- SHAMT_W, 4, shift-amount width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready at a clk edge
- alu_op  in  7  one-hot: 0000001 ADD, 0000010 SUB, 0000100 AND, 0001000 OR, 0010000 NOT, 0100000 SHR, 1000000 SHL, 0000000 no ALU op
- op_a, op_b  in  WIDTH  operands
- shamt  in  SHAMT_W  shift amount for SHR/SHL
- flag_cmd  in  2  00 none, 01 set C, 10 clear C, 11 none; honoured only when alu_op = 0
- dest_in  in  3  destination register index
- wb_en_in  in  1  write-back enable
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  one-cycle pulse: result/out_dest/out_wb_en valid
- result  out  WIDTH  registered result
- out_dest  out  3  registered destination
- out_wb_en  out  1  registered write-back enable
- flag_z, flag_n, flag_c  out  1  condition flags
- illegal  out  1  one-cycle pulse: accepted alu_op not one-hot and nonzero

## Operation
- FSM states: IDLE and SHIFT. in_ready = (state == IDLE).
- Accept in IDLE with a single-cycle op or alu_op = 0:
  - result, out_dest and out_wb_en register on the accept edge; out_valid pulses the next cycle.
  - ADD: result = a + b. C = carry out.
  - SUB: result = a - b. C = borrow (1 iff a < b unsigned).
  - AND, OR: bitwise; NOT: result = ~a. C unchanged for all three.
  - alu_op = 0: result = a, flags unchanged, flag_cmd applied to C.
- Z/N update for every ALU op: Z = (result == 0), N = result[WIDTH-1].
- Illegal op (more than one bit set): behaves as alu_op = 0 with flag_cmd ignored; illegal pulses alongside out_valid.
- SHR/SHL with shamt = 0: single-cycle path. result = a, Z/N updated, C unchanged.
- SHR/SHL with shamt = k ≥ 1:
  - Accept edge loads working register = a, counter = k, latches op/dest/wb_en, state → SHIFT.
  - Each SHIFT edge shifts the working register by 1 (zero fill) and decrements the counter.
  - C = last bit shifted out: SHL → a[WIDTH-k], SHR → a[k-1].
  - On the edge where the counter goes 1 → 0: result and flags register, out_valid pulses, state → IDLE.
- Flags change only on edges that raise out_valid, or on flag_cmd accepts.
- Outputs hold their values while out_valid is low.
- flush: highest synchronous priority.
  - Aborts SHIFT → IDLE with no out_valid, and flags unchanged.
  - in_valid is ignored on the flush edge.
  - Takes no effect on a result already registered (its out_valid still pulses).
- Reset (asynchronous, any time including mid-shift):
  - state IDLE.
  - result = 0, out_dest = 0, out_wb_en = 0.
  - out_valid = 0, illegal = 0.
  - flag_z = flag_n = flag_c = 0, counter = 0.
  - No transfers occur while rst_n is low.

## Timing
- Single-cycle ops: accept at edge E0 → out_valid high for the cycle after E0. Throughput 1 per cycle; in_ready stays high.
- Shift by k ≥ 1:
  - Accept at E0; in_ready low from after E0 until after Ek (k cycles).
  - out_valid high for the cycle after Ek.
  - Earliest next accept is E(k+1).
- No output backpressure: the write-back stage always takes out_valid.
- flag outputs reflect the new value in the same cycle that out_valid is high.
- Arithmetic is modulo 2^WIDTH.

## Test plan
- ADD 0x7FFF + 0x0001 → one cycle after accept: result 0x8000, N=1, Z=0, C=0, out_valid single pulse.
- SUB 0x0005 − 0x0005 → 0x0000, Z=1, C=0; then SUB 0x0003 − 0x0005 → 0xFFFE, N=1, C=1 on back-to-back cycles.
- SHL 0x9001 by 4 → in_ready low 4 cycles; result 0x0010, C=1 after E4. Then SHR 0x0003 by 1 → 0x0001, C=1 after E1. alu_op=0 with flag_cmd=10 → C=0, result = a.
- alu_op 0000011, a = 0x1234 → result 0x1234, illegal pulses with out_valid, flags unchanged.
- SHL 0xFFFF by 8, flush asserted at E3 → state IDLE, no out_valid, flags unchanged, in_ready high the next cycle. New ADD 1+1 accepted → 0x0002.
- SHR by 15 with rst_n pulsed low mid-shift → all outputs and flags 0 immediately. in_ready high; the aborted shift never produces out_valid.
